sevenseg_pair_decoder: RTL and testbench
========================================

Name: sevenseg_pair_decoder

Overview:
- Reverse of the byte-to-seven-segment encoder. Accepts two 8-bit seven-segment patterns (Dig1 = high nibble, Dig2 = low nibble) strobed in one at a time on a shared segment bus.
- Decodes each pattern to a hex nibble, pairs the two nibbles into a byte and presents it with a one-cycle valid pulse.
- Sits on the capture side of a display loopback path; used for self-check of the encoder and for reading segment data back into logic.

Parameters:
- TIMEOUT, 16, cycles allowed in WAIT_LO before the pending high nibble is discarded (legal range 2..255).

Ports:
- Clock  input  1  system clock, rising edge.
- Reset  input  1  asynchronous, active-high reset.
- SegStrobe  input  1  SegIn/SegSel valid this cycle.
- SegSel  input  1  0 = Dig1 (high nibble), 1 = Dig2 (low nibble).
- SegIn  input  8  pattern, bit order 0gfedcba; bit7 must be 0.
- Value  output  8  last decoded byte; holds until next pair completes.
- ValueValid  output  1  one-cycle pulse when Value updates.
- PatternErr  output  1  one-cycle pulse: strobed pattern not in table.
- OrderErr  output  1  one-cycle pulse: Dig2 strobed with no pending Dig1.
- TimeoutErr  output  1  one-cycle pulse: WAIT_LO timed out.
- PairCount  output  8  count of completed pairs; wraps 255->0.

Behaviour:
- Reset: clock and reset as stated under Ports. All outputs go to 0 immediately; state = IDLE; timer = 0; pending nibble = 0.
- Decode table (hex in -> nibble), exact match only:
  - 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7
  - 7F->8, 6F->9, 77->A, 7C->B, 39->C, 5E->D, 79->E, 71->F
- Any other value, including any pattern with bit7 = 1, is invalid.
- Every output is registered. Each response appears on the cycle after the strobe edge.
- FSM states: IDLE, WAIT_LO.
- IDLE:
  - Strobe, Sel=0, valid pattern: latch high nibble, timer=0, go to WAIT_LO.
  - Strobe, Sel=1, valid pattern: OrderErr pulse, stay in IDLE.
  - Strobe, invalid pattern (either Sel): PatternErr pulse, stay in IDLE.
- WAIT_LO, timer increments each cycle without a strobe:
  - Strobe, Sel=1, valid pattern: Value={hi,lo}, ValueValid pulse, PairCount+1, go to IDLE.
  - Strobe, Sel=0, valid pattern: overwrite high nibble, timer=0, stay in WAIT_LO, no error.
  - Strobe, invalid pattern: PatternErr pulse, discard high nibble, go to IDLE. Value is unchanged.
  - No strobe and timer == TIMEOUT-1: TimeoutErr pulse, go to IDLE.
- Simultaneous events:
  - A strobe on the timeout cycle takes priority; no TimeoutErr.
  - At most one error pulse per cycle.
  - ValueValid and the error pulses are mutually exclusive.
- Reset asserted mid-pair discards the pending nibble. Value and PairCount clear to 0.
- SegSel and SegIn are ignored when SegStrobe=0.
- Back-to-back strobes every cycle are supported; throughput is one byte per 2 cycles.

Test Plan:
- Reset, then strobe Sel=0/SegIn=7D, next cycle Sel=1/SegIn=7F -> ValueValid pulses 1 cycle after the second strobe, Value=0x68, PairCount=1, no errors.
- Strobe Sel=0/SegIn=3F, then Sel=1/SegIn=71 -> Value=0x0F. Then strobe Sel=0/SegIn=66, Sel=0/SegIn=79, Sel=1/SegIn=5E -> Value=0xED, no OrderErr.
- In IDLE, strobe Sel=0/SegIn=FD (bit7 set) -> PatternErr pulse, Value unchanged. Then strobe Sel=1/SegIn=06 -> OrderErr pulse.
- TIMEOUT=16: strobe Sel=0/SegIn=6D then idle 16 cycles -> TimeoutErr pulses exactly once. A later Sel=1/SegIn=4F -> OrderErr, not ValueValid.
- Same as above but Sel=1/SegIn=4F arrives on the timeout cycle -> Value=0x53, ValueValid pulse, no TimeoutErr.
- 256 consecutive valid pairs -> PairCount wraps to 0. Assert Reset between Dig1 and Dig2 -> all outputs 0 and the following Dig2 raises OrderErr.

Source files
------------

// File: rtl/sevenseg_pair_decoder.sv
// sevenseg_pair_decoder
// Capture-side partner of the byte-to-seven-segment encoder. Two segment
// patterns arrive one at a time on a shared bus: first the high digit
// (sel=0), then the low digit (sel=1). Each pattern is decoded back to a hex
// nibble. The two nibbles are joined into one byte and presented with a
// single-cycle valid pulse. Malformed patterns, a low digit with no pending
// high digit, and a high digit left waiting too long each raise their own
// single-cycle error pulse. Every output is registered, so each response
// appears one cycle after the strobe edge that caused it.
module sevenseg_pair_decoder #(
  // Idle cycles tolerated in WAIT_LO before the pending high nibble is
  // dropped. Legal range is 2..255.
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       seg_strobe_i,
  input  logic       seg_sel_i,
  input  logic [7:0] seg_in_i,
  output logic [7:0] value_o,
  output logic       value_valid_o,
  output logic       pattern_err_o,
  output logic       order_err_o,
  output logic       timeout_err_o,
  output logic [7:0] pair_count_o
);

  // The timer counts 0..TIMEOUT-1, so 8 bits are enough for the whole legal
  // range. The timeout fires on the cycle where the timer sits at its last
  // value and no strobe arrives.
  localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_WAIT_LO = 1'b1
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] hi_q, hi_d;
  logic [7:0] timer_q, timer_d;
  logic [7:0] value_q, value_d;
  logic [7:0] count_q, count_d;
  logic       value_valid_q, value_valid_d;
  logic       pattern_err_q, pattern_err_d;
  logic       order_err_q, order_err_d;
  logic       timeout_err_q, timeout_err_d;

  logic [3:0] seg_nibble;
  logic       seg_known;

  // Decode the segment pattern (bit order 0gfedcba). Only an exact match
  // is accepted, so any pattern with bit7 set is rejected by the default arm.
  always_comb begin
    seg_nibble = 4'h0;
    seg_known  = 1'b1;
    case (seg_in_i)
      8'h3F: seg_nibble = 4'h0;
      8'h06: seg_nibble = 4'h1;
      8'h5B: seg_nibble = 4'h2;
      8'h4F: seg_nibble = 4'h3;
      8'h66: seg_nibble = 4'h4;
      8'h6D: seg_nibble = 4'h5;
      8'h7D: seg_nibble = 4'h6;
      8'h07: seg_nibble = 4'h7;
      8'h7F: seg_nibble = 4'h8;
      8'h6F: seg_nibble = 4'h9;
      8'h77: seg_nibble = 4'hA;
      8'h7C: seg_nibble = 4'hB;
      8'h39: seg_nibble = 4'hC;
      8'h5E: seg_nibble = 4'hD;
      8'h79: seg_nibble = 4'hE;
      8'h71: seg_nibble = 4'hF;
      default: begin
        seg_nibble = 4'h0;
        seg_known  = 1'b0;
      end
    endcase
  end

  // Next-state and output logic. A strobe is examined before the timeout,
  // so a strobe on the timeout cycle wins and no TimeoutErr is raised.
  // The branches are disjoint, so at most one pulse is raised per cycle.
  always_comb begin
    state_d       = state_q;
    hi_d          = hi_q;
    timer_d       = timer_q;
    value_d       = value_q;
    count_d       = count_q;
    value_valid_d = 1'b0;
    pattern_err_d = 1'b0;
    order_err_d   = 1'b0;
    timeout_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (seg_strobe_i) begin
          if (!seg_known) begin
            pattern_err_d = 1'b1;
          end else if (seg_sel_i) begin
            // A low digit with nothing to pair it with.
            order_err_d = 1'b1;
          end else begin
            hi_d    = seg_nibble;
            timer_d = 8'd0;
            state_d = S_WAIT_LO;
          end
        end
      end

      S_WAIT_LO: begin
        if (seg_strobe_i) begin
          if (!seg_known) begin
            // A bad pattern breaks the pair. Value keeps its old contents.
            pattern_err_d = 1'b1;
            hi_d          = 4'h0;
            timer_d       = 8'd0;
            state_d       = S_IDLE;
          end else if (seg_sel_i) begin
            value_d       = {hi_q, seg_nibble};
            value_valid_d = 1'b1;
            count_d       = count_q + 8'd1;
            timer_d       = 8'd0;
            state_d       = S_IDLE;
          end else begin
            // A repeated high digit replaces the pending one and restarts
            // the wait. This is not treated as an error.
            hi_d    = seg_nibble;
            timer_d = 8'd0;
          end
        end else if (timer_q == TIMER_LAST) begin
          timeout_err_d = 1'b1;
          hi_d          = 4'h0;
          timer_d       = 8'd0;
          state_d       = S_IDLE;
        end else begin
          timer_d = timer_q + 8'd1;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers. Reset clears everything at once, which also
  // discards a half-received pair.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_IDLE;
      hi_q          <= 4'h0;
      timer_q       <= 8'd0;
      value_q       <= 8'd0;
      count_q       <= 8'd0;
      value_valid_q <= 1'b0;
      pattern_err_q <= 1'b0;
      order_err_q   <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hi_q          <= hi_d;
      timer_q       <= timer_d;
      value_q       <= value_d;
      count_q       <= count_d;
      value_valid_q <= value_valid_d;
      pattern_err_q <= pattern_err_d;
      order_err_q   <= order_err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign value_o       = value_q;
  assign value_valid_o = value_valid_q;
  assign pattern_err_o = pattern_err_q;
  assign order_err_o   = order_err_q;
  assign timeout_err_o = timeout_err_q;
  assign pair_count_o  = count_q;

endmodule

// File: tb/tb_sevenseg_pair_decoder.sv
// Testbench for sevenseg_pair_decoder. It runs in four parts:
//   1. A directed table of vectors with hand-computed expected outputs.
//   2. Randomized traffic checked against a behavioural model.
//   3. A run of 256 pairs to check that the pair counter wraps.
//   4. A reset asserted in the middle of a pair.
// Each applied cycle prints one line.
module tb_sevenseg_pair_decoder;

  localparam int TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       strobe = 1'b0;
  logic       sel = 1'b0;
  logic [7:0] seg = 8'h00;
  logic [7:0] value;
  logic       vv, perr, oerr, terr;
  logic [7:0] cnt;

  int checks = 0;
  int errors = 0;

  sevenseg_pair_decoder #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .seg_strobe_i(strobe),
    .seg_sel_i(sel),
    .seg_in_i(seg),
    .value_o(value),
    .value_valid_o(vv),
    .pattern_err_o(perr),
    .order_err_o(oerr),
    .timeout_err_o(terr),
    .pair_count_o(cnt)
  );

  always #5 clk = ~clk;

  // Segment patterns for hex digits 0..F.
  logic [7:0] pats [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                            8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  // Behavioural model: a pending high digit, and the number of idle cycles
  // since that digit arrived.
  bit         m_pending;
  logic [3:0] m_hi;
  int         m_idle;
  logic [7:0] m_value;
  logic [7:0] m_count;
  logic       e_vv, e_perr, e_oerr, e_terr;

  function automatic int lookup(input logic [7:0] p);
    for (int k = 0; k < 16; k++) if (pats[k] == p) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_pending = 0; m_hi = 0; m_idle = 0; m_value = 0; m_count = 0;
    e_vv = 0; e_perr = 0; e_oerr = 0; e_terr = 0;
  endtask

  task automatic model_step(input logic s, input logic sl, input logic [7:0] p);
    int idx;
    idx = lookup(p);
    e_vv = 0; e_perr = 0; e_oerr = 0; e_terr = 0;
    if (s) begin
      if (idx < 0) begin
        e_perr = 1;
        m_pending = 0;
      end else if (sl) begin
        if (m_pending) begin
          m_value = m_hi * 16 + idx;
          m_count = m_count + 1;
          e_vv = 1;
          m_pending = 0;
        end else begin
          e_oerr = 1;
        end
      end else begin
        m_pending = 1;
        m_hi = 4'(idx);
        m_idle = 0;
      end
    end else if (m_pending) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        e_terr = 1;
        m_pending = 0;
      end
    end
  endtask

  task automatic check(input string name, input logic [7:0] xv, input logic xvv,
                       input logic xpe, input logic xoe, input logic xte, input logic [7:0] xc);
    checks++;
    if (value !== xv || vv !== xvv || perr !== xpe || oerr !== xoe || terr !== xte || cnt !== xc) begin
      errors++;
      $display("FAIL %s: got value=%h vv=%b perr=%b oerr=%b terr=%b cnt=%0d, expected value=%h vv=%b perr=%b oerr=%b terr=%b cnt=%0d",
               name, value, vv, perr, oerr, terr, cnt, xv, xvv, xpe, xoe, xte, xc);
    end else begin
      $display("ok   %s: value=%h vv=%b perr=%b oerr=%b terr=%b cnt=%0d", name, value, vv, perr, oerr, terr, cnt);
    end
  endtask

  // Drive one cycle's inputs at the falling edge. Outputs are sampled 1 time
  // unit after the next rising edge, and the model is stepped once per cycle.
  task automatic apply(input logic s, input logic sl, input logic [7:0] p);
    @(negedge clk);
    strobe = s; sel = sl; seg = p;
    @(posedge clk);
    #1;
    model_step(s, sl, p);
  endtask

  task automatic apply_model(input string name, input logic s, input logic sl, input logic [7:0] p);
    apply(s, sl, p);
    check(name, m_value, e_vv, e_perr, e_oerr, e_terr, m_count);
  endtask

  typedef struct {
    logic       s;
    logic       sl;
    logic [7:0] p;
    logic [7:0] xv;
    logic       xvv, xpe, xoe, xte;
    logic [7:0] xc;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic sl, input logic [7:0] p, input logic [7:0] xv,
                     input logic xvv, input logic xpe, input logic xoe, input logic xte, input logic [7:0] xc);
    vec_t v;
    v.s = s; v.sl = sl; v.p = p; v.xv = xv;
    v.xvv = xvv; v.xpe = xpe; v.xoe = xoe; v.xte = xte; v.xc = xc;
    vecs.push_back(v);
  endtask

  initial begin
    logic [7:0] c0;
    int i;

    model_reset();

    // Directed vectors. Idle cycles carry garbage on sel/seg, which the
    // design must ignore because strobe is low.
    add(1, 0, 8'h7D, 8'h00, 0, 0, 0, 0, 8'd0);
    add(1, 1, 8'h7F, 8'h68, 1, 0, 0, 0, 8'd1);
    add(1, 0, 8'h3F, 8'h68, 0, 0, 0, 0, 8'd1);
    add(1, 1, 8'h71, 8'h0F, 1, 0, 0, 0, 8'd2);
    add(1, 0, 8'h66, 8'h0F, 0, 0, 0, 0, 8'd2);
    add(1, 0, 8'h79, 8'h0F, 0, 0, 0, 0, 8'd2);
    add(1, 1, 8'h5E, 8'hED, 1, 0, 0, 0, 8'd3);
    add(1, 0, 8'hFD, 8'hED, 0, 1, 0, 0, 8'd3);
    add(1, 1, 8'h06, 8'hED, 0, 0, 1, 0, 8'd3);
    // A high digit followed by 16 idle cycles: only the 16th reports a timeout.
    add(1, 0, 8'h6D, 8'hED, 0, 0, 0, 0, 8'd3);
    for (i = 0; i < 15; i++) add(0, 1, 8'h06, 8'hED, 0, 0, 0, 0, 8'd3);
    add(0, 1, 8'h06, 8'hED, 0, 0, 0, 1, 8'd3);
    add(0, 0, 8'h00, 8'hED, 0, 0, 0, 0, 8'd3);
    add(1, 1, 8'h4F, 8'hED, 0, 0, 1, 0, 8'd3);
    // The same sequence, but the low digit arrives on the timeout cycle.
    add(1, 0, 8'h6D, 8'hED, 0, 0, 0, 0, 8'd3);
    for (i = 0; i < 15; i++) add(0, 0, 8'h6F, 8'hED, 0, 0, 0, 0, 8'd3);
    add(1, 1, 8'h4F, 8'h53, 1, 0, 0, 0, 8'd4);
    add(0, 0, 8'h00, 8'h53, 0, 0, 0, 0, 8'd4);
    // A bad pattern in WAIT_LO drops the pending digit, so the next low
    // digit has nothing to pair with.
    add(1, 0, 8'h3F, 8'h53, 0, 0, 0, 0, 8'd4);
    add(1, 1, 8'h80, 8'h53, 0, 1, 0, 0, 8'd4);
    add(1, 1, 8'h06, 8'h53, 0, 0, 1, 0, 8'd4);

    // Reset state, held across two clock edges.
    strobe = 0; sel = 0; seg = 0; rst = 1;
    #12;
    check("reset_state", 8'h00, 0, 0, 0, 0, 8'd0);
    @(negedge clk);
    rst = 0;

    foreach (vecs[k]) begin
      apply(vecs[k].s, vecs[k].sl, vecs[k].p);
      check($sformatf("vec%0d", k), vecs[k].xv, vecs[k].xvv, vecs[k].xpe, vecs[k].xoe, vecs[k].xte, vecs[k].xc);
    end

    // Random traffic. Strobes become sparser in each later phase, so that
    // timeouts occur as well as back-to-back pairs.
    for (int n = 0; n < 3000; n++) begin
      logic       s_r, sl_r;
      logic [7:0] p_r;
      int         den;
      den  = (n < 1000) ? 2 : (n < 2000) ? 8 : 24;
      s_r  = ($urandom_range(den - 1) == 0);
      sl_r = 1'($urandom_range(1));
      p_r  = ($urandom_range(3) != 0) ? pats[$urandom_range(15)] : 8'($urandom);
      apply_model($sformatf("rand%0d", n), s_r, sl_r, p_r);
    end

    // 256 back-to-back pairs must bring the pair counter back to its start.
    c0 = m_count;
    for (int n = 0; n < 256; n++) begin
      apply_model($sformatf("wrap_hi%0d", n), 1, 0, pats[n % 16]);
      apply_model($sformatf("wrap_lo%0d", n), 1, 1, pats[(n / 16) % 16]);
    end
    checks++;
    if (cnt !== c0) begin
      errors++;
      $display("FAIL pair_count_wrap: got %0d, expected %0d", cnt, c0);
    end else begin
      $display("ok   pair_count_wrap: cnt=%0d", cnt);
    end

    // Reset between the high and low digits. The outputs clear without a
    // clock edge, and the following low digit must raise OrderErr.
    apply_model("pre_reset_hi", 1, 0, 8'h07);
    @(negedge clk);
    strobe = 0;
    #2 rst = 1;
    #1;
    check("async_reset", 8'h00, 0, 0, 0, 0, 8'd0);
    @(negedge clk);
    rst = 0;
    model_reset();
    apply_model("post_reset_lo", 1, 1, 8'h06);
    checks++;
    if (oerr !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_order_err: got %b, expected 1", oerr);
    end else begin
      $display("ok   post_reset_order_err: oerr=%b", oerr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
